sao_deci_fsm: RTL and testbench

//  Control FSM of the SAO decision stage; the consumer side of the statistics FSM handshake.
//  - Detects "statistics ready" for each component (Y, then Cb, then Cr).
//  - Holds isWorking_deci high while it sequences the RD-cost candidates: 4 EO classes, then BO band starts.
//  - Ends each component with a best-select cycle and a done cycle.
//  - isWorking_deci is the level the statistics FSM uses to clear its end_of_*_st flags.

---
 rtl/sao_deci_fsm.sv | 152 +++++++++++++++
 tb/tb_sao_deci_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sao_deci_fsm.sv
// SAO decision-stage control FSM: consumes "statistics ready" edges per
// component (Y, Cb, Cr) and sequences the EO then BO RD-cost candidates,
// finishing each component with a best-select cycle and a done cycle.
module sao_deci_fsm #(
    parameter int EO_CLASS_NUM = 4,
    parameter int BO_BAND_NUM  = 29,
    parameter int CYC_PER_CAND = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_o,
    input  logic       end_of_luma_st,
    input  logic       end_of_chroma_st,
    output logic       isWorking_deci,
    output logic [1:0] deci_cIdx,
    output logic       deci_mode,
    output logic [4:0] cand_idx,
    output logic [1:0] sub_cyc,
    output logic       cand_last,
    output logic       sel_best,
    output logic       deci_done,
    output logic       ctu_done,
    output logic       err_seq
);

    typedef enum logic [2:0] {S_IDLE, S_EO, S_BO, S_SEL, S_DONE} state_t;

    localparam logic [4:0] EO_LAST  = 5'(EO_CLASS_NUM - 1);
    localparam logic [4:0] BO_LAST  = 5'(BO_BAND_NUM - 1);
    localparam logic [1:0] SUB_LAST = 2'(CYC_PER_CAND - 1);

    state_t     state_q, state_d;
    logic [1:0] exp_c_q, exp_c_d;
    logic [1:0] cidx_q, cidx_d;
    logic [4:0] cand_q, cand_d;
    logic [1:0] sub_q, sub_d;
    logic       pend_q, pend_d;
    logic       err_q, err_d;
    logic       luma_prev_q, chroma_prev_q;

    logic luma_edge, chroma_edge, luma_ok, chroma_ok, req_valid;
    logic consume, req_used;

    // State, counters, pending slot and edge history; en_o=0 freezes all
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            exp_c_q       <= 2'd0;
            cidx_q        <= 2'd0;
            cand_q        <= 5'd0;
            sub_q         <= 2'd0;
            pend_q        <= 1'b0;
            err_q         <= 1'b0;
            luma_prev_q   <= 1'b0;
            chroma_prev_q <= 1'b0;
        end else if (en_o) begin
            state_q       <= state_d;
            exp_c_q       <= exp_c_d;
            cidx_q        <= cidx_d;
            cand_q        <= cand_d;
            sub_q         <= sub_d;
            pend_q        <= pend_d;
            err_q         <= err_d;
            luma_prev_q   <= end_of_luma_st;
            chroma_prev_q <= end_of_chroma_st;
        end
    end

    // Request qualification, state sequencing and pending-slot bookkeeping
    always_comb begin
        state_d  = state_q;
        exp_c_d  = exp_c_q;
        cidx_d   = cidx_q;
        cand_d   = cand_q;
        sub_d    = sub_q;
        err_d    = err_q;
        consume  = 1'b0;
        req_used = 1'b0;

        luma_edge   = end_of_luma_st & ~luma_prev_q;
        chroma_edge = end_of_chroma_st & ~chroma_prev_q;
        luma_ok     = (exp_c_q == 2'd0);
        chroma_ok   = (exp_c_q != 2'd0);
        req_valid   = (luma_edge & luma_ok) | (chroma_edge & chroma_ok);
        // Luma/chroma validity is mutually exclusive, so with both edges
        // present exactly one is taken and the other flags an error here.
        if ((luma_edge & ~luma_ok) | (chroma_edge & ~chroma_ok))
            err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (pend_q || req_valid) begin
                    consume  = pend_q;
                    req_used = ~pend_q;
                    state_d  = S_EO;
                    cidx_d   = exp_c_q;
                    cand_d   = 5'd0;
                    sub_d    = 2'd0;
                end
            end
            S_EO, S_BO: begin
                sub_d = sub_q + 2'd1;
                if (sub_q == SUB_LAST) begin
                    sub_d  = 2'd0;
                    cand_d = cand_q + 5'd1;
                    if (state_q == S_EO && cand_q == EO_LAST) begin
                        state_d = S_BO;
                        cand_d  = 5'd0;
                    end else if (state_q == S_BO && cand_q == BO_LAST) begin
                        state_d = S_SEL;
                        cand_d  = 5'd0;
                    end
                end
            end
            S_SEL: state_d = S_DONE;
            S_DONE: begin
                exp_c_d = (exp_c_q == 2'd2) ? 2'd0 : exp_c_q + 2'd1;
                if (pend_q) begin
                    // Back-to-back run: the new run reports the advanced component
                    consume = 1'b1;
                    state_d = S_EO;
                    cidx_d  = exp_c_d;
                    cand_d  = 5'd0;
                    sub_d   = 2'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pend_d = pend_q & ~consume;
        if (req_valid && !req_used) begin
            if (pend_q && !consume) err_d  = 1'b1;
            else                    pend_d = 1'b1;
        end
    end

    assign isWorking_deci = (state_q != S_IDLE);
    assign deci_cIdx      = cidx_q;
    assign deci_mode      = (state_q == S_BO);
    assign cand_idx       = cand_q;
    assign sub_cyc        = sub_q;
    assign cand_last      = (sub_q == SUB_LAST) &&
                            (((state_q == S_EO) && (cand_q == EO_LAST)) ||
                             ((state_q == S_BO) && (cand_q == BO_LAST)));
    assign sel_best       = (state_q == S_SEL);
    assign deci_done      = (state_q == S_DONE);
    assign ctu_done       = (state_q == S_DONE) && (cidx_q == 2'd2);
    assign err_seq        = err_q;

endmodule

// File: tb/tb_sao_deci_fsm.sv
// Bench for sao_deci_fsm: directed scenarios plus random flag/enable/reset
// traffic, every cycle compared against a run-position reference model.
module tb_sao_deci_fsm;

    localparam int EO  = 4;
    localparam int BO  = 29;
    localparam int CPC = 2;
    localparam int EO_LEN = EO * CPC;
    localparam int BO_LEN = BO * CPC;
    localparam int RUN = EO_LEN + BO_LEN + 2;

    logic       clk = 1'b0;
    logic       rst_n, en_o, luma, chroma;
    logic       isWorking_deci, deci_mode, cand_last, sel_best, deci_done, ctu_done, err_seq;
    logic [1:0] deci_cIdx, sub_cyc;
    logic [4:0] cand_idx;

    sao_deci_fsm #(.EO_CLASS_NUM(EO), .BO_BAND_NUM(BO), .CYC_PER_CAND(CPC)) dut (
        .clk(clk), .rst_n(rst_n), .en_o(en_o),
        .end_of_luma_st(luma), .end_of_chroma_st(chroma),
        .isWorking_deci(isWorking_deci), .deci_cIdx(deci_cIdx), .deci_mode(deci_mode),
        .cand_idx(cand_idx), .sub_cyc(sub_cyc), .cand_last(cand_last),
        .sel_best(sel_best), .deci_done(deci_done), .ctu_done(ctu_done), .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a run is just a position 0..RUN-1
    bit m_busy, m_pend, m_err, m_pl, m_pc;
    int m_pos, m_cidx, m_exp;

    int cnt_work, cnt_sel, cnt_done, cnt_ctu;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit le, ce, lv, cv, rv;
        if (!rst_n) begin
            m_busy = 0; m_pend = 0; m_err = 0; m_pl = 0; m_pc = 0;
            m_pos = 0; m_cidx = 0; m_exp = 0;
        end else if (en_o) begin
            le = luma & !m_pl;
            ce = chroma & !m_pc;
            lv = le && (m_exp == 0);
            cv = ce && (m_exp != 0);
            rv = lv || cv;
            if ((le && !lv) || (ce && !cv)) m_err = 1;
            if (!m_busy) begin
                if (m_pend || rv) begin
                    m_busy = 1; m_pos = 0; m_cidx = m_exp;
                    m_pend = m_pend && rv;
                end
            end else if (m_pos == RUN - 1) begin
                m_exp = (m_exp + 1) % 3;
                if (m_pend) begin
                    m_pos = 0; m_cidx = m_exp;
                end else begin
                    m_busy = 0;
                end
                m_pend = rv;
            end else begin
                m_pos++;
                if (rv) begin
                    if (m_pend) m_err = 1;
                    else        m_pend = 1;
                end
            end
            m_pl = luma;
            m_pc = chroma;
        end
    endtask

    task automatic check_all();
        int e_mode, e_cand, e_sub, e_last, e_sel, e_done;
        e_mode = 0; e_cand = 0; e_sub = 0; e_last = 0; e_sel = 0; e_done = 0;
        if (m_busy) begin
            if (m_pos < EO_LEN) begin
                e_cand = m_pos / CPC; e_sub = m_pos % CPC;
                e_last = (m_pos == EO_LEN - 1);
            end else if (m_pos < EO_LEN + BO_LEN) begin
                e_mode = 1;
                e_cand = (m_pos - EO_LEN) / CPC; e_sub = (m_pos - EO_LEN) % CPC;
                e_last = (m_pos == EO_LEN + BO_LEN - 1);
            end else if (m_pos == RUN - 2) e_sel = 1;
            else e_done = 1;
        end
        chk("working", isWorking_deci, m_busy);
        chk("cidx", deci_cIdx, m_cidx);
        chk("mode", deci_mode, e_mode);
        chk("cand", cand_idx, e_cand);
        chk("sub", sub_cyc, e_sub);
        chk("cand_last", cand_last, e_last);
        chk("sel_best", sel_best, e_sel);
        chk("deci_done", deci_done, e_done);
        chk("ctu_done", ctu_done, e_done && (m_cidx == 2));
        chk("err_seq", err_seq, m_err);
    endtask

    task automatic cyc(input bit r, input bit e, input bit l, input bit c);
        rst_n = r; en_o = e; luma = l; chroma = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        cnt_work += isWorking_deci;
        cnt_sel  += sel_best;
        cnt_done += deci_done;
        cnt_ctu  += ctu_done;
    endtask

    task automatic clr_cnt();
        cnt_work = 0; cnt_sel = 0; cnt_done = 0; cnt_ctu = 0;
    endtask

    initial begin
        rst_n = 0; en_o = 1; luma = 0; chroma = 0;
        @(negedge clk);

        // Reset state
        repeat (3) cyc(0, 1, 0, 0);
        chk("rst_working", isWorking_deci, 0);
        chk("rst_err", err_seq, 0);

        // Single luma run: 68 busy cycles, one select and one done
        clr_cnt();
        repeat (9) cyc(1, 1, 0, 0);
        repeat (80) cyc(1, 1, 1, 0);
        chk("t1_len", cnt_work, RUN);
        chk("t1_sel", cnt_sel, 1);
        chk("t1_done", cnt_done, 1);
        chk("t1_ctu", cnt_ctu, 0);

        // Cb then Cr runs; ctu_done only in the Cr done cycle
        clr_cnt();
        repeat (75) cyc(1, 1, 1, 1);
        repeat (3)  cyc(1, 1, 1, 0);
        repeat (75) cyc(1, 1, 1, 1);
        chk("t2_done", cnt_done, 2);
        chk("t2_ctu", cnt_ctu, 1);
        chk("t2_err", err_seq, 0);

        // Luma run, then Cb run with the Cr edge arriving mid-run: no gap
        repeat (3)  cyc(1, 1, 0, 0);
        repeat (75) cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 1);
        repeat (38) cyc(1, 1, 1, 1);
        cyc(1, 1, 1, 0);
        clr_cnt();
        repeat (2 * RUN + 10) begin
            cyc(1, 1, 1, 1);
        end
        chk("t3_back2back", cnt_work, RUN - 40 + RUN);
        chk("t3_ctu", cnt_ctu, 1);
        chk("t3_err", err_seq, 0);

        // Invalid chroma edge at exp_c==0, then overflow of the pending slot
        repeat (2) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 1);
        chk("t4_bad_edge", err_seq, 1);
        repeat (2) cyc(0, 1, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 0);
        chk("t4_pend_ok", err_seq, 0);
        cyc(1, 1, 1, 0);
        chk("t4_overflow", err_seq, 1);
        repeat (150) cyc(1, 1, 0, 0);
        chk("t4_sticky", err_seq, 1);

        // Enable stall in BO at cand_idx=7 stretches the run by 5 cycles
        repeat (2) cyc(0, 1, 0, 0);
        clr_cnt();
        cyc(1, 1, 1, 0);
        repeat (EO_LEN + 14) cyc(1, 1, 1, 0);
        chk("t5_at_cand7", cand_idx, 7);
        repeat (5) cyc(1, 0, 1, 0);
        chk("t5_frozen", cand_idx, 7);
        repeat (80) cyc(1, 1, 1, 0);
        chk("t5_len", cnt_work, RUN + 5);
        chk("t5_done", cnt_done, 1);

        // Reset mid-EO, then a fresh luma run
        repeat (2) cyc(0, 1, 0, 0);
        repeat (4) cyc(1, 1, 1, 0);
        cyc(0, 1, 1, 0);
        chk("t6_rst_work", isWorking_deci, 0);
        chk("t6_rst_cidx", deci_cIdx, 0);
        repeat (3) cyc(1, 1, 0, 0);
        repeat (5) cyc(1, 1, 1, 0);
        chk("t6_restart_cidx", deci_cIdx, 0);
        chk("t6_restart_work", isWorking_deci, 1);

        // Random traffic
        for (int i = 0; i < 20000; i++) begin
            bit r, e, l, c;
            r = ($urandom_range(0, 999) != 0);
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 59) == 0) ? ~luma : luma;
            c = ($urandom_range(0, 39) == 0) ? ~chroma : chroma;
            cyc(r, e, l, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
